// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a FWFT FIFO into a one-entry valid/ready output register in bursts of burst_len.
// Optional idle-timeout flush is built when FIFO_RD_TIMEOUT_EN is defined.
module fifo_burst_reader #(
   parameter int DATA_WIDTH     = 4,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH+1:0] fifo_word_count,
   input  logic [DATA_WIDTH-1:0] fifo_r_data,
   output logic                  fifo_rd,
   input  logic [ADDR_WIDTH:0]   burst_len,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic [7:0]            burst_cnt
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH:0]   remaining, remaining_nx;
   logic [ADDR_WIDTH:0]   eff_len, start_beats;
   logic                  flush_pending, flush_pending_nx;
   logic                  start, timeout_hit, beat_done;

   assign eff_len   = (burst_len == '0) ? (ADDR_WIDTH+1)'(1) : burst_len;
   assign beat_done = m_valid & m_ready & m_last;
   assign busy      = (state == BURST);

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   // Hitting the threshold starts the short burst in the same cycle, like a pending flush.
   assign timeout_hit = (state == IDLE) && !fifo_empty && (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         to_cnt <= '0;
      else if ((state == IDLE) && !fifo_empty && !start)
         to_cnt <= to_cnt + 1'b1;
      else
         to_cnt <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nx         = state;
      remaining_nx     = remaining;
      flush_pending_nx = flush_pending | flush;
      start            = 1'b0;
      fifo_rd          = 1'b0;
      start_beats      = eff_len;
      if (fifo_word_count < {1'b0, eff_len})
         start_beats = fifo_word_count[ADDR_WIDTH:0];

      case (state)
         IDLE: begin
            if (fifo_word_count >= {1'b0, eff_len}) begin
               start        = 1'b1;
               state_nx     = BURST;
               remaining_nx = start_beats;
            end else if ((flush_pending || timeout_hit) && !fifo_empty) begin
               start            = 1'b1;
               state_nx         = BURST;
               remaining_nx     = start_beats;
               flush_pending_nx = flush;
            end else if (flush_pending && fifo_empty) begin
               flush_pending_nx = flush;
            end
         end
         BURST: begin
            fifo_rd = (remaining != '0) && !fifo_empty && (!m_valid || m_ready);
            if (fifo_rd)
               remaining_nx = remaining - 1'b1;
            if (beat_done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         remaining     <= '0;
         flush_pending <= 1'b0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         m_last        <= 1'b0;
         burst_cnt     <= '0;
      end else begin
         state         <= state_nx;
         remaining     <= remaining_nx;
         flush_pending <= flush_pending_nx;
         if (fifo_rd) begin
            m_data  <= fifo_r_data;
            m_valid <= 1'b1;
            m_last  <= (remaining == (ADDR_WIDTH+1)'(1));
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if ((state == BURST) && beat_done)
            burst_cnt <= burst_cnt + 8'd1;
      end
   end

endmodule
